// File: rtl/rsa_operand_rx.sv
// UART receiver that assembles a 12-byte operand packet into exponent,
// modulus and message words and hands them to the RSA core with valid/ack.
module rsa_operand_rx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter int NUM_BYTES    = 12,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  input  logic        load_ack,
  output logic [31:0] exponent,
  output logic [31:0] modulus,
  output logic [31:0] message,
  output logic        operands_valid,
  output logic        frame_err,
  output logic        overrun,
  output logic [3:0]  byte_count
);

  localparam int TMR_W    = $clog2(CLKS_PER_BIT);
  localparam int STAGE_W  = NUM_BYTES * 8;
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [TMR_W-1:0] HALF_BIT  = TMR_W'(CLKS_PER_BIT / 2);
  localparam logic [TMR_W-1:0] LAST_TICK = TMR_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_LIMIT - 1);
  localparam logic [3:0]       LAST_BYTE = 4'(NUM_BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic               r_rxMeta;
  logic               r_rxSync;
  logic [TMR_W-1:0]   r_bitTimer;
  logic [2:0]         r_bitCnt;
  logic [7:0]         r_dataShift;
  logic [TO_W-1:0]    r_idleCnt;
  logic [STAGE_W-9:0] r_staging;
  logic [31:0]        r_exponent;
  logic [31:0]        r_modulus;
  logic [31:0]        r_message;
  logic               r_valid;
  logic               r_frameErr;
  logic               r_overrun;
  logic [3:0]         r_byteCount;

  logic               w_timerClr;
  logic               w_sampleData;
  logic               w_stopSample;
  logic               w_byteOk;
  logic               w_stopBad;
  logic               w_timeout;
  logic [STAGE_W-1:0] w_stageNext;

  assign w_byteOk    = w_stopSample & r_rxSync;
  assign w_stopBad   = w_stopSample & ~r_rxSync;
  assign w_timeout   = (r_state == S_IDLE) && (r_byteCount != 4'd0) && (r_idleCnt == TO_LAST);
  assign w_stageNext = {r_dataShift, r_staging};

  assign exponent       = r_exponent;
  assign modulus        = r_modulus;
  assign message        = r_message;
  assign operands_valid = r_valid;
  assign frame_err      = r_frameErr;
  assign overrun        = r_overrun;
  assign byte_count     = r_byteCount;

  // Two-flop synchronizer; idles high so reset cannot fake a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rxMeta <= 1'b1;
      r_rxSync <= 1'b1;
    end else begin
      r_rxMeta <= rx;
      r_rxSync <= r_rxMeta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state logic and sample strobes for start, data and stop bits.
  always_comb begin
    w_nextState  = r_state;
    w_timerClr   = 1'b0;
    w_sampleData = 1'b0;
    w_stopSample = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!r_rxSync) begin
          w_nextState = S_START;
          w_timerClr  = 1'b1;
        end
      end
      S_START: begin
        if (r_bitTimer == HALF_BIT) begin
          w_timerClr  = 1'b1;
          w_nextState = r_rxSync ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_bitTimer == LAST_TICK) begin
          w_timerClr   = 1'b1;
          w_sampleData = 1'b1;
          if (r_bitCnt == 3'd7) w_nextState = S_STOP;
        end
      end
      S_STOP: begin
        if (r_bitTimer == LAST_TICK) begin
          w_timerClr   = 1'b1;
          w_stopSample = 1'b1;
          w_nextState  = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  // Bit timer, data-bit counter and LSB-first byte shifter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_bitTimer  <= '0;
      r_bitCnt    <= 3'd0;
      r_dataShift <= 8'd0;
    end else begin
      if (w_timerClr || r_state == S_IDLE) r_bitTimer <= '0;
      else                                 r_bitTimer <= r_bitTimer + 1'b1;
      if (r_state == S_START)  r_bitCnt <= 3'd0;
      else if (w_sampleData)   r_bitCnt <= r_bitCnt + 3'd1;
      if (w_sampleData) r_dataShift <= {r_rxSync, r_dataShift[7:1]};
    end
  end

  // Inter-byte idle counter; only runs while a partial packet is pending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idleCnt <= '0;
    end else if (r_state != S_IDLE || r_byteCount == 4'd0 || w_timeout) begin
      r_idleCnt <= '0;
    end else begin
      r_idleCnt <= r_idleCnt + 1'b1;
    end
  end

  // Packet assembly, operand load, handshake and error pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_staging   <= '0;
      r_exponent  <= 32'd0;
      r_modulus   <= 32'd0;
      r_message   <= 32'd0;
      r_valid     <= 1'b0;
      r_frameErr  <= 1'b0;
      r_overrun   <= 1'b0;
      r_byteCount <= 4'd0;
    end else begin
      r_frameErr <= w_stopBad | w_timeout;
      r_overrun  <= w_byteOk & r_valid;
      if (r_valid && load_ack) r_valid <= 1'b0;
      if (w_stopBad || w_timeout) begin
        r_byteCount <= 4'd0;
        r_staging   <= '0;
      end else if (w_byteOk && !r_valid) begin
        if (r_byteCount == LAST_BYTE) begin
          r_exponent  <= w_stageNext[31:0];
          r_modulus   <= w_stageNext[63:32];
          r_message   <= w_stageNext[95:64];
          r_valid     <= 1'b1;
          r_byteCount <= 4'd0;
          r_staging   <= '0;
        end else begin
          r_staging   <= w_stageNext[STAGE_W-1:8];
          r_byteCount <= r_byteCount + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rsa_operand_rx.sv
// Self-checking bench for rsa_operand_rx: serial packets in, operands checked
// against a queue of expected packets built as the bytes are sent.
module tb_rsa_operand_rx;

  localparam int CPB = 16;
  localparam int TOB = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic        load_ack = 1'b0;
  logic [31:0] exponent;
  logic [31:0] modulus;
  logic [31:0] message;
  logic        operands_valid;
  logic        frame_err;
  logic        overrun;
  logic [3:0]  byte_count;

  typedef struct {
    logic [31:0] e;
    logic [31:0] m;
    logic [31:0] g;
  } exp_t;

  exp_t expQ[$];
  exp_t cur;
  exp_t held;

  int errors = 0;
  int checks = 0;
  int ferrCount = 0;
  int ovrCount = 0;
  int base;

  rsa_operand_rx #(
    .CLKS_PER_BIT(CPB),
    .NUM_BYTES(12),
    .TIMEOUT_BITS(TOB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .load_ack(load_ack),
    .exponent(exponent),
    .modulus(modulus),
    .message(message),
    .operands_valid(operands_valid),
    .frame_err(frame_err),
    .overrun(overrun),
    .byte_count(byte_count)
  );

  // 100 MHz clock.
  always #5 clk = ~clk;

  // Count every cycle each pulse output is high.
  always @(negedge clk) begin
    if (frame_err === 1'b1) ferrCount++;
    if (overrun === 1'b1) ovrCount++;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    rx = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      waitCycles(CPB);
    end
    rx = stopBit;
    waitCycles(CPB);
    rx = 1'b1;
  endtask

  task automatic sendRange(input logic [95:0] pkt, input int first, input int last);
    for (int k = first; k <= last; k++) sendByte(pkt[8*k +: 8], 1'b1);
  endtask

  task automatic pushExpected(input logic [95:0] pkt);
    exp_t x;
    x.e = {pkt[31:24], pkt[23:16], pkt[15:8], pkt[7:0]};
    x.m = {pkt[63:56], pkt[55:48], pkt[47:40], pkt[39:32]};
    x.g = {pkt[95:88], pkt[87:80], pkt[79:72], pkt[71:64]};
    expQ.push_back(x);
  endtask

  task automatic sendPacket(input logic [95:0] pkt);
    pushExpected(pkt);
    sendRange(pkt, 0, 11);
  endtask

  task automatic doAck();
    load_ack = 1'b1;
    @(negedge clk);
    load_ack = 1'b0;
  endtask

  task automatic popExpected();
    if (expQ.size() == 0) begin
      cur.e = 32'hxxxxxxxx;
      cur.m = 32'hxxxxxxxx;
      cur.g = 32'hxxxxxxxx;
    end else begin
      cur = expQ.pop_front();
    end
  endtask

  // Reset values while reset is held, then release.
  task automatic test_reset();
    waitCycles(3);
    checks++;
    if ({exponent, modulus, message} !== 96'd0) begin
      errors++;
      $display("[TB] FAIL reset_operands: got %h expected 0", {exponent, modulus, message});
    end
    checks++;
    if ({operands_valid, frame_err, overrun, byte_count} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0", {operands_valid, frame_err, overrun, byte_count});
    end
    reset = 1'b1;
    waitCycles(2 * CPB);
  endtask

  // Plan item 1: basic packet, valid, byte_count and ack.
  task automatic test_basic_packet();
    base = ferrCount;
    sendPacket({8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h8D, 8'hFD, 8'h00, 8'h01, 8'h00, 8'h01});
    popExpected();
    checks++;
    if (operands_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL basic_valid: got %b expected 1", operands_valid);
    end
    checks++;
    if (byte_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d expected 0", byte_count);
    end
    checks++;
    if (exponent !== 32'h00010001 || exponent !== cur.e) begin
      errors++;
      $display("[TB] FAIL basic_exponent: got %h expected %h", exponent, cur.e);
    end
    checks++;
    if (modulus !== 32'h00008DFD || modulus !== cur.m) begin
      errors++;
      $display("[TB] FAIL basic_modulus: got %h expected %h", modulus, cur.m);
    end
    checks++;
    if (message !== 32'h00000005 || message !== cur.g) begin
      errors++;
      $display("[TB] FAIL basic_message: got %h expected %h", message, cur.g);
    end
    checks++;
    if (ferrCount - base != 0) begin
      errors++;
      $display("[TB] FAIL basic_no_ferr: got %0d pulses expected 0", ferrCount - base);
    end
    doAck();
    checks++;
    if (operands_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ack_clears_valid: got %b expected 0", operands_valid);
    end
    checks++;
    if ({exponent, modulus, message} !== {cur.e, cur.m, cur.g}) begin
      errors++;
      $display("[TB] FAIL ack_retains: got %h expected %h", {exponent, modulus, message}, {cur.e, cur.m, cur.g});
    end
    held = cur;
  endtask

  // Plan item 2: short low glitch is not a byte.
  task automatic test_glitch();
    base = ferrCount;
    rx = 1'b0;
    waitCycles(5);
    rx = 1'b1;
    waitCycles(3 * CPB);
    checks++;
    if (byte_count !== 4'd0 || ferrCount - base != 0) begin
      errors++;
      $display("[TB] FAIL glitch_ignored: got count %0d ferr %0d expected 0 0", byte_count, ferrCount - base);
    end
    sendPacket(96'h1122_3344_5566_7788_99AA_BBCC);
    popExpected();
    checks++;
    if ({operands_valid, exponent, modulus, message} !== {1'b1, cur.e, cur.m, cur.g}) begin
      errors++;
      $display("[TB] FAIL glitch_packet: got %b %h %h %h expected 1 %h %h %h",
               operands_valid, exponent, modulus, message, cur.e, cur.m, cur.g);
    end
    doAck();
    held = cur;
  endtask

  // Plan item 3: bad stop bit drops the partial packet.
  task automatic test_stop_error();
    base = ferrCount;
    sendRange(96'h0, 0, 3);
    checks++;
    if (byte_count !== 4'd4) begin
      errors++;
      $display("[TB] FAIL stop_partial_count: got %0d expected 4", byte_count);
    end
    sendByte(8'h5A, 1'b0);
    waitCycles(3 * CPB);
    checks++;
    if (ferrCount - base != 1) begin
      errors++;
      $display("[TB] FAIL stop_ferr_pulse: got %0d pulses expected 1", ferrCount - base);
    end
    checks++;
    if (byte_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL stop_count_cleared: got %0d expected 0", byte_count);
    end
    checks++;
    if ({operands_valid, exponent, modulus, message} !== {1'b0, held.e, held.m, held.g}) begin
      errors++;
      $display("[TB] FAIL stop_operands_kept: got %b %h %h %h expected 0 %h %h %h",
               operands_valid, exponent, modulus, message, held.e, held.m, held.g);
    end
    sendPacket(96'hDEAD_BEEF_0BAD_F00D_CAFE_1234);
    popExpected();
    checks++;
    if ({operands_valid, exponent, modulus, message} !== {1'b1, cur.e, cur.m, cur.g}) begin
      errors++;
      $display("[TB] FAIL stop_then_packet: got %b %h %h %h expected 1 %h %h %h",
               operands_valid, exponent, modulus, message, cur.e, cur.m, cur.g);
    end
    doAck();
    held = cur;
  endtask

  // Plan item 4: inter-byte timeout versus a gap just under the limit.
  task automatic test_timeout();
    base = ferrCount;
    sendRange(96'h0102_0304_0506_0708_090A_0B0C, 0, 2);
    checks++;
    if (byte_count !== 4'd3) begin
      errors++;
      $display("[TB] FAIL timeout_partial_count: got %0d expected 3", byte_count);
    end
    waitCycles(TOB * CPB + 60);
    checks++;
    if (ferrCount - base != 1 || byte_count !== 4'd0) begin
      errors++;
      $display("[TB] FAIL timeout_fires: got ferr %0d count %0d expected 1 0", ferrCount - base, byte_count);
    end
    checks++;
    if ({operands_valid, exponent} !== {1'b0, held.e}) begin
      errors++;
      $display("[TB] FAIL timeout_operands_kept: got %b %h expected 0 %h", operands_valid, exponent, held.e);
    end
    base = ferrCount;
    pushExpected(96'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3);
    sendRange(96'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3, 0, 2);
    waitCycles(600);
    checks++;
    if (ferrCount - base != 0 || byte_count !== 4'd3) begin
      errors++;
      $display("[TB] FAIL gap_no_timeout: got ferr %0d count %0d expected 0 3", ferrCount - base, byte_count);
    end
    sendRange(96'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3, 3, 11);
    popExpected();
    checks++;
    if ({operands_valid, exponent, modulus, message} !== {1'b1, cur.e, cur.m, cur.g}) begin
      errors++;
      $display("[TB] FAIL gap_packet: got %b %h %h %h expected 1 %h %h %h",
               operands_valid, exponent, modulus, message, cur.e, cur.m, cur.g);
    end
    doAck();
    held = cur;
  endtask

  // Plan item 5: byte while operands are held is dropped with an overrun.
  task automatic test_overrun();
    sendPacket(96'h0000_0007_0000_00BB_0001_0001);
    popExpected();
    held = cur;
    checks++;
    if (operands_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_setup_valid: got %b expected 1", operands_valid);
    end
    base = ovrCount;
    sendByte(8'hAA, 1'b1);
    waitCycles(4);
    checks++;
    if (ovrCount - base != 1) begin
      errors++;
      $display("[TB] FAIL overrun_pulse: got %0d pulses expected 1", ovrCount - base);
    end
    checks++;
    if ({operands_valid, byte_count, exponent, modulus, message} !== {1'b1, 4'd0, held.e, held.m, held.g}) begin
      errors++;
      $display("[TB] FAIL overrun_state_kept: got %b %0d %h %h %h expected 1 0 %h %h %h",
               operands_valid, byte_count, exponent, modulus, message, held.e, held.m, held.g);
    end
    doAck();
    sendPacket(96'h7654_3210_FEDC_BA98_1357_9BDF);
    popExpected();
    checks++;
    if ({operands_valid, exponent, modulus, message} !== {1'b1, cur.e, cur.m, cur.g}) begin
      errors++;
      $display("[TB] FAIL overrun_next_packet: got %b %h %h %h expected 1 %h %h %h",
               operands_valid, exponent, modulus, message, cur.e, cur.m, cur.g);
    end
  endtask

  // Plan item 6: asynchronous reset in the middle of byte 7.
  task automatic test_reset_mid();
    doAck();
    sendRange(96'h1111_2222_3333_4444_5555_6666, 0, 5);
    rx = 1'b0;
    waitCycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = i[0];
      waitCycles(CPB);
    end
    rx = 1'b1;
    waitCycles(CPB / 2);
    reset = 1'b0;
    #1;
    checks++;
    if ({exponent, modulus, message} !== 96'd0) begin
      errors++;
      $display("[TB] FAIL midreset_operands: got %h expected 0", {exponent, modulus, message});
    end
    checks++;
    if ({operands_valid, frame_err, overrun, byte_count} !== 7'd0) begin
      errors++;
      $display("[TB] FAIL midreset_flags: got %b expected 0", {operands_valid, frame_err, overrun, byte_count});
    end
    waitCycles(5);
    reset = 1'b1;
    waitCycles(2 * CPB);
    sendPacket(96'h0BAD_CAFE_8000_0001_0000_0003);
    popExpected();
    checks++;
    if ({operands_valid, exponent, modulus, message} !== {1'b1, cur.e, cur.m, cur.g}) begin
      errors++;
      $display("[TB] FAIL midreset_packet: got %b %h %h %h expected 1 %h %h %h",
               operands_valid, exponent, modulus, message, cur.e, cur.m, cur.g);
    end
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drained: got %0d left expected 0", expQ.size());
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_basic_packet();
    test_glitch();
    test_stop_error();
    test_timeout();
    test_overrun();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rsa_operand_rx.md
Name: rsa_operand_rx

Overview:
- UART receive front-end that collects the 12-byte operand packet from the host serial line.
- Assembles the packet into three 32-bit operands (exponent, modulus, message) and presents them to the RSA core with a valid/ack handshake.
- Sits directly upstream of the modular-exponentiation datapath. Operand registers are held stable until the next complete packet arrives.

Parameters:
CLKS_PER_BIT, 5208, clock cycles per UART bit (50 MHz / 9600 baud); minimum 8
NUM_BYTES, 12, bytes per operand packet (fixed at 12 for the 3x32 layout)
TIMEOUT_BITS, 40, idle bit-periods after a byte before a partial packet is discarded

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx  in  1  UART serial input, asynchronous, idle high
load_ack  in  1  downstream accepts operands; consumed only while operands_valid=1
exponent  out  32  packet bytes 0..3, little-endian (byte 0 = bits 7:0)
modulus  out  32  packet bytes 4..7, little-endian
message  out  32  packet bytes 8..11, little-endian
operands_valid  out  1  complete packet held, level until acked
frame_err  out  1  one-cycle pulse: bad stop bit or inter-byte timeout
overrun  out  1  one-cycle pulse: byte received while operands_valid=1 (byte dropped)
byte_count  out  4  bytes collected in current packet, 0..11

Behaviour:
- Reset (reset=0, asynchronous):
  - exponent, modulus and message = 0; operands_valid = 0; frame_err = 0; overrun = 0; byte_count = 0.
  - Both synchronizer flops = 1; FSM = IDLE.
- rx passes through a 2-flop synchronizer. All decisions use the synchronized value rxs.
- Bit timer: counts 0..CLKS_PER_BIT-1. Half-bit point = CLKS_PER_BIT/2 (integer division).
- FSM:
  - IDLE: on rxs=0, go to START and clear the timer.
  - START: at the half-bit point, if rxs=0 go to DATA and restart the timer; if rxs=1 it was a glitch, return to IDLE with no byte and no error.
  - DATA: sample rxs every CLKS_PER_BIT cycles, 8 samples, LSB first into the byte shifter. Then go to STOP.
  - STOP: sample once after CLKS_PER_BIT cycles, then return to IDLE in the next cycle.
    - Stop bit = 1: byte accepted.
    - Stop bit = 0: frame_err pulses, byte_count -> 0, byte discarded.
- Packet assembly on an accepted byte:
  - If operands_valid=0: the byte is shifted in as staging = {byte, staging[95:8]} and byte_count increments.
  - When the 12th byte is accepted:
    - exponent = staging[31:0], modulus = staging[63:32], message = staging[95:64];
    - operands_valid rises on the clock after the stop-bit sample;
    - byte_count -> 0.
  - If operands_valid=1: the byte is dropped, overrun pulses 1 cycle, byte_count is unchanged.
- Handshake:
  - load_ack=1 while operands_valid=1: operands_valid -> 0 next cycle; operand outputs are retained.
  - load_ack while operands_valid=0 is ignored.
  - A byte accepted in the same cycle as an ack is judged on pre-ack state, so it is dropped with an overrun pulse.
- Timeout:
  - An idle counter runs while byte_count != 0 and the FSM is in IDLE.
  - When it reaches TIMEOUT_BITS*CLKS_PER_BIT: byte_count -> 0, staging is discarded, frame_err pulses.
  - A start bit clears the counter.
  - With byte_count = 0 there is no timeout.
- Operand outputs change only on 12th-byte completion or reset. A partial or failed packet never disturbs them.
- Reset mid-byte or mid-packet: everything returns to reset values immediately. The next falling edge after release starts a fresh packet.
- frame_err and overrun are never high for more than one cycle per event.

Test Plan (CLKS_PER_BIT=16, TIMEOUT_BITS=40 for speed):
1. Send bytes 01 00 01 00 FD 8D 00 00 05 00 00 00 with 1 stop bit each -> exponent=0x00010001, modulus=0x00008DFD, message=0x00000005. operands_valid rises 1 cycle after the 12th stop sample; byte_count returns to 0. Pulse load_ack -> valid=0 next cycle, operands unchanged.
2. Drive rx low for 5 cycles then high -> no byte, byte_count stays 0, frame_err stays 0. Then send a valid packet -> accepted normally.
3. Send 4 good bytes, then a 5th with stop bit = 0 -> frame_err pulses once, byte_count=0, prior operands unchanged. Then a full good packet -> valid with the correct values.
4. Send 3 bytes, then idle for 640+ cycles -> frame_err pulses at the timeout, byte_count=0. Idling 600 cycles instead produces no error, and the packet completes.
5. With operands_valid=1 and no ack, send byte AA -> overrun pulses once, byte_count=0, operands unchanged. Ack and send a new packet -> new values loaded.
6. Assert reset during data bit 4 of byte 7 -> all outputs 0 immediately. After release, a full packet -> correct operands, valid=1.
